// File: rtl/puf_response_collector.sv
// rtl/puf_response_collector.sv - arbiter PUF sequencer: LFSR challenges, launch pulses, majority-voted response byte
module puf_response_collector #(
  parameter int         SETTLE_CYCLES = 4,
  parameter int         VOTES         = 5,
  parameter logic [7:0] SEED          = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       seed_load,
  input  logic [7:0] seed_in,
  output logic [7:0] challenge,
  output logic       pulse,
  input  logic       resp_in,
  output logic [7:0] resp_byte,
  output logic       resp_valid,
  output logic       busy
);

  localparam int VW = $clog2(VOTES + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  localparam logic [VW-1:0] LAST_VOTE   = VW'(VOTES - 1);
  localparam logic [VW-1:0] MAJORITY    = VW'((VOTES + 1) / 2);
  localparam logic [SW-1:0] LAST_SETTLE = SW'(SETTLE_CYCLES - 1);

  if (VOTES < 1 || (VOTES % 2) == 0) begin : g_votes_check
    $error("puf_response_collector: VOTES must be odd and >= 1");
  end
  if (SETTLE_CYCLES < 1) begin : g_settle_check
    $error("puf_response_collector: SETTLE_CYCLES must be >= 1");
  end
  if (SEED == 8'h00) begin : g_seed_check
    $error("puf_response_collector: SEED must be nonzero");
  end

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [VW-1:0] vote_cnt;
  logic [VW-1:0] ones_cnt;
  logic [VW-1:0] ones_sum;
  logic [2:0]    bit_cnt;
  logic [SW-1:0] settle_cnt;
  logic [7:0]    shift_reg;
  logic [7:0]    shift_next;
  logic [7:0]    lfsr_next;
  logic          voted_bit;
  logic          decide;
  logic          seed_take;

  always_comb begin
    state_next = state;
    decide     = 1'b0;
    seed_take  = 1'b0;
    // ones_sum includes the sample being taken this cycle
    ones_sum   = ones_cnt + VW'(resp_in);
    voted_bit  = (ones_sum >= MAJORITY);
    shift_next = {shift_reg[6:0], voted_bit};
    lfsr_next  = {challenge[6:0], challenge[7] ^ challenge[5] ^ challenge[4] ^ challenge[3]};

    case (state)
      IDLE: begin
        if (start) begin
          state_next = LAUNCH;
        end else if (seed_load) begin
          seed_take = 1'b1;
        end
      end
      LAUNCH: begin
        state_next = SETTLE;
      end
      SETTLE: begin
        if (settle_cnt == LAST_SETTLE) begin
          state_next = SAMPLE;
        end
      end
      SAMPLE: begin
        if (vote_cnt == LAST_VOTE) begin
          decide     = 1'b1;
          state_next = (bit_cnt == 3'd7) ? DONE : LAUNCH;
        end else begin
          state_next = LAUNCH;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      challenge  <= SEED;
      pulse      <= 1'b0;
      resp_valid <= 1'b0;
      busy       <= 1'b0;
      resp_byte  <= 8'h00;
      shift_reg  <= 8'h00;
      vote_cnt   <= '0;
      ones_cnt   <= '0;
      bit_cnt    <= 3'd0;
      settle_cnt <= '0;
    end else begin
      state      <= state_next;
      // outputs are registered from the next state so they line up with it
      pulse      <= (state_next == LAUNCH);
      resp_valid <= (state_next == DONE);
      busy       <= (state_next != IDLE);

      if (state == IDLE && start) begin
        bit_cnt  <= 3'd0;
        vote_cnt <= '0;
        ones_cnt <= '0;
      end

      if (seed_take) begin
        challenge <= (seed_in == 8'h00) ? 8'h01 : seed_in;
      end

      if (state == LAUNCH) begin
        settle_cnt <= '0;
      end else if (state == SETTLE) begin
        settle_cnt <= settle_cnt + SW'(1);
      end

      if (state == SAMPLE) begin
        if (decide) begin
          vote_cnt  <= '0;
          ones_cnt  <= '0;
          shift_reg <= shift_next;
          challenge <= lfsr_next;
          bit_cnt   <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            resp_byte <= shift_next;
          end
        end else begin
          vote_cnt <= vote_cnt + VW'(1);
          ones_cnt <= ones_sum;
        end
      end
    end
  end

endmodule

// File: doc/puf_response_collector.md
Name: puf_response_collector

Overview:
- Sequencer that sits directly upstream of the arbiter PUF core and also consumes its output.
- Generates 8-bit challenges from an internal LFSR and fires launch pulses into the PUF.
- Samples the 1-bit PUF response after a fixed settle time and takes a majority vote over repeated launches.
- Packs eight voted bits into one response byte with a single-cycle valid strobe for the TinyTapeout wrapper.

Parameters:
- SETTLE_CYCLES, 4, idle cycles between launch pulse and response sample; must be >= 1.
- VOTES, 5, launches per challenge; must be odd and >= 1, even value is an elaboration error.
- SEED, 8'hA5, challenge value after reset; must be nonzero.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin one 8-bit collection; honoured only in IDLE
- seed_load  in  1  load seed_in into LFSR; honoured only in IDLE
- seed_in  in  8  new LFSR seed
- challenge  out  8  current challenge to PUF, registered
- pulse  out  1  PUF launch pulse, registered, one cycle wide
- resp_in  in  1  PUF response bit
- resp_byte  out  8  last collected response byte, registered
- resp_valid  out  1  one-cycle strobe, resp_byte updated
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (sync, dominates all inputs): challenge=SEED, pulse=0, resp_byte=0, resp_valid=0, busy=0, state=IDLE, all counters 0.
- Reset mid-operation aborts the run. No resp_valid is produced and resp_byte returns to 0.
- FSM states: IDLE, LAUNCH, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 → LAUNCH; clear bit_cnt, vote_cnt and ones_cnt.
  - seed_load=1 with start=0 → challenge<=seed_in, with seed_in=0 forced to 8'h01.
  - start and seed_load together: start wins, seed ignored.
- LAUNCH: pulse=1 for exactly this cycle; challenge stable → SETTLE.
- SETTLE: pulse=0; stay SETTLE_CYCLES cycles → SAMPLE.
- SAMPLE: ones_cnt += resp_in.
  - vote_cnt < VOTES-1: vote_cnt++ → LAUNCH.
  - Else, decide the bit: bit = (ones_cnt_including_this_sample >= (VOTES+1)/2).
  - On the decision, shift the bit in: shift_reg <= {shift_reg[6:0], bit}. First challenge's bit ends in bit 7.
  - Also advance the LFSR one step and clear vote_cnt and ones_cnt.
  - bit_cnt < 7: bit_cnt++ → LAUNCH. bit_cnt == 7 → DONE, with resp_byte <= completed shift value.
- DONE: resp_valid=1 for this cycle only; busy=1 → IDLE. start is ignored here; start held high re-triggers from IDLE on the next cycle.
- LFSR step: challenge <= {challenge[6:0], challenge[7]^challenge[5]^challenge[4]^challenge[3]}. Challenge never advances during the votes of one bit. It holds its value in IDLE and DONE.
- Timing:
  - Each vote = SETTLE_CYCLES+2 cycles.
  - From the edge that samples start, state enters DONE after 8*VOTES*(SETTLE_CYCLES+2) edges; default 240.
  - resp_valid is high during that cycle.
- Pulses per run: exactly 8*VOTES (default 40).
- resp_byte holds its value until the next DONE or reset.
- Counter widths: ones_cnt and vote_cnt sized clog2(VOTES+1); bit_cnt 3 bits; settle counter clog2(SETTLE_CYCLES+1).

Test Plan:
- Reset → challenge=8'hA5, pulse=0, resp_byte=0, resp_valid=0, busy=0. Hold start=1 during rst=1 → still IDLE.
- resp_in tied 1, start pulse → 40 pulses; challenge sequence A5,4A,95,2A,54,A9,53,A7.
  - resp_valid high exactly one cycle, 240 edges after start.
  - resp_byte=8'hFF; challenge=8'h4E afterwards; busy low the next cycle.
- resp_in driven as challenge[0] → resp_byte=8'hA7.
- Per-bit vote pattern 1,1,0,0,0 → resp_byte=8'h00. Pattern 1,1,1,0,0 → 8'hFF. Pattern 0,0,1,1,1 → 8'hFF.
- Seed handling:
  - seed_load with seed_in=8'h00 in IDLE → challenge=8'h01.
  - seed_load with seed_in=8'h3C while busy → ignored.
  - start during DONE → ignored, no second run.
- rst asserted at cycle 100 of a run:
  - Next cycle: IDLE, challenge=A5, pulse=0, busy=0.
  - No resp_valid within the following 300 cycles without start.
